jump_sequencer: RTL

Parametrised jump/branch execution unit for the CPU's Group 2 (jump) instructions, sitting between the instruction decoder, the register file and the memory bus. It takes over the jump group's combinational mux-select role and runs each jump as a multi-cycle sequence: it evaluates a selectable condition code, fetches an immediate or indirect target over a ready/valid memory handshake, computes the next PC and the link value, and optionally keeps a hardware return-address stack.

---
 rtl/jump_pkg.sv | 29 ++
 rtl/jump_link_stack.sv | 47 ++++
 rtl/jump_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/jump_pkg.sv
// Shared encodings for the jump group: JPF modes, SKIPF codes, FSM states, instruction sizes.
// Pure declarations; no latency or backpressure of its own.
package jump_pkg;

    localparam logic [1:0] JPF_RB  = 2'b00;
    localparam logic [1:0] JPF_IND = 2'b01;
    localparam logic [1:0] JPF_S16 = 2'b10;
    localparam logic [1:0] JPF_JR  = 2'b11;

    localparam logic [1:0] SKIPF_ALW0 = 2'b00;
    localparam logic [1:0] SKIPF_ALW1 = 2'b01;
    localparam logic [1:0] SKIPF_CC   = 2'b10;
    localparam logic [1:0] SKIPF_NCC  = 2'b11;

    localparam int unsigned INSN_SIZE_SHORT = 2;
    localparam int unsigned INSN_SIZE_LONG  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_READ   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    function automatic logic cond_taken(input logic [1:0] skipf, input logic cc);
        return ~skipf[1] | (cc ^ skipf[0]);
    endfunction

endpackage

// File: rtl/jump_link_stack.sv
// link_stack: DEPTH x WIDTH LIFO of return addresses; push/pop take effect at the clock edge.
// Zero-latency top-of-stack read; push when full and pop when empty are ignored.
module link_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] r_sp;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;

    assign o_full   = (r_sp == PTR_W'(DEPTH));
    assign o_empty  = (r_sp == '0);
    assign w_wr_idx = IDX_W'(r_sp);
    assign w_rd_idx = IDX_W'(r_sp - 1'b1);
    assign o_top    = r_mem[w_rd_idx];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read below the stack pointer.
    always_ff @(posedge CLK) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_din;
        end
    end

endmodule

// File: rtl/jump_sequencer.sv
// Multi-cycle jump unit: condition eval, target fetch, PC/link update; JUMP_LINK_STACK_EN adds a return stack.
// Latency START->PC_LOAD 2 cycles, or 3+ with a read; MEM_RD held with stable MEM_ADDR until MEM_RDY.
module jump_sequencer
    import jump_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int NUM_CC     = 4,
    parameter int CCSEL_W    = $clog2(NUM_CC),
    parameter int LINK_DEPTH = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               RET,
    input  logic [1:0]         SKIPF,
    input  logic [CCSEL_W-1:0] CCF,
    input  logic [1:0]         JPF,
    input  logic               JLF,
    input  logic [NUM_CC-1:0]  FLAGS,
    input  logic [ADDR_W-1:0]  PC,
    input  logic [ADDR_W-1:0]  REGB_DOUT,
    input  logic [ADDR_W-1:0]  MEM_DIN,
    input  logic               MEM_RDY,
    output logic               MEM_RD,
    output logic [ADDR_W-1:0]  MEM_ADDR,
    output logic               PC_LOAD,
    output logic [ADDR_W-1:0]  PC_NEXT,
    output logic               LINK_WE,
    output logic [ADDR_W-1:0]  LINK_DATA,
    output logic               BUSY,
    output logic               STACK_ERR
);
    if (LINK_DEPTH < 1) begin : g_bad_depth
        $error("LINK_DEPTH must be at least 1");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_regb;
    logic [NUM_CC-1:0]   r_flags;
    logic [1:0]          r_skipf;
    logic [1:0]          r_jpf;
    logic [CCSEL_W-1:0]  r_ccf;
    logic                r_jlf;
    logic                r_ret;
    logic                r_link;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   r_pc_next;
    logic [ADDR_W-1:0]   r_link_data;

    logic                w_cc;
    logic                w_taken;
    logic                w_need_read;
    logic [ADDR_W-1:0]   w_size;
    logic [ADDR_W-1:0]   w_pc_seq;
    logic [ADDR_W-1:0]   w_eval_next;
    logic [ADDR_W-1:0]   w_stk_top;
    logic                w_stk_empty;

    // Indices beyond the populated flags read as a false condition.
    always_comb begin
        w_cc = 1'b0;
        for (int i = 0; i < NUM_CC; i++) begin
            if (r_ccf == CCSEL_W'(i)) begin
                w_cc = r_flags[i];
            end
        end
    end

`ifdef JUMP_LINK_STACK_EN
    assign w_taken = cond_taken(r_skipf, w_cc);
`else
    assign w_taken = ~r_ret & cond_taken(r_skipf, w_cc);
`endif

    assign w_size      = (r_ret || !r_jpf[1]) ? ADDR_W'(INSN_SIZE_SHORT) : ADDR_W'(INSN_SIZE_LONG);
    assign w_pc_seq    = r_pc + w_size;
    assign w_need_read = w_taken & ~r_ret & (r_jpf != JPF_RB);

    always_comb begin
        w_eval_next = w_pc_seq;
        if (w_taken) begin
            if (r_ret) begin
                w_eval_next = w_stk_empty ? w_pc_seq : w_stk_top;
            end else begin
                w_eval_next = r_regb;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (START) w_state_nxt = ST_EVAL;
            ST_EVAL:   w_state_nxt = w_need_read ? ST_READ : ST_COMMIT;
            ST_READ:   if (MEM_RDY) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pc        <= '0;
            r_regb      <= '0;
            r_flags     <= '0;
            r_skipf     <= '0;
            r_jpf       <= '0;
            r_ccf       <= '0;
            r_jlf       <= 1'b0;
            r_ret       <= 1'b0;
            r_link      <= 1'b0;
            r_mem_addr  <= '0;
            r_pc_next   <= '0;
            r_link_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_pc    <= PC;
                        r_regb  <= REGB_DOUT;
                        r_flags <= FLAGS;
                        r_skipf <= SKIPF;
                        r_jpf   <= JPF;
                        r_ccf   <= CCF;
                        r_jlf   <= JLF;
                        r_ret   <= RET;
                    end
                end
                ST_EVAL: begin
                    // Returns never link; only forward jumps write/push a return address.
                    r_link      <= w_taken & r_jlf & ~r_ret;
                    r_link_data <= w_pc_seq;
                    if (w_need_read) begin
                        r_mem_addr <= (r_jpf == JPF_IND) ? r_regb : r_pc + ADDR_W'(INSN_SIZE_SHORT);
                    end else begin
                        r_pc_next <= w_eval_next;
                    end
                end
                ST_READ: begin
                    if (MEM_RDY) begin
                        r_pc_next <= (r_jpf == JPF_JR) ? r_pc + MEM_DIN : MEM_DIN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign MEM_RD    = (r_state == ST_READ);
    assign MEM_ADDR  = r_mem_addr;
    assign PC_LOAD   = (r_state == ST_COMMIT);
    assign PC_NEXT   = r_pc_next;
    assign LINK_WE   = (r_state == ST_COMMIT) & r_link;
    assign LINK_DATA = r_link_data;
    assign BUSY      = (r_state != ST_IDLE);

`ifdef JUMP_LINK_STACK_EN
    logic w_push;
    logic w_pop;
    logic w_stk_full;
    logic w_stk_err_set;
    logic r_stack_err;

    assign w_push        = (r_state == ST_COMMIT) & r_link;
    assign w_pop         = (r_state == ST_EVAL) & r_ret & w_taken & ~w_stk_empty;
    assign w_stk_err_set = (w_push & w_stk_full)
                         | ((r_state == ST_EVAL) & r_ret & w_taken & w_stk_empty);

    link_stack #(
        .DEPTH (LINK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_link_stack (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (r_link_data),
        .o_top   (w_stk_top),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_stack_err <= 1'b0;
        end else if (w_stk_err_set) begin
            r_stack_err <= 1'b1;
        end
    end

    assign STACK_ERR = r_stack_err;
`else
    assign w_stk_top   = '0;
    assign w_stk_empty = 1'b1;
    assign STACK_ERR   = 1'b0;
`endif

endmodule
